// File: rtl/spi_user_pkg.sv
// rtl/spi_user_pkg.sv - shared command bytes, pad byte and state encoding for the user SPI channel
package spi_user_pkg;
   localparam logic [7:0] CMD_BUTTONS = 8'hF4;
   localparam logic [7:0] CMD_READ    = 8'hF5;
   localparam logic [7:0] PAD_BYTE    = 8'h00;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CMD    = 3'd1,
      ST_SEND   = 3'd2,
      ST_DONE   = 3'd3,
      ST_IGNORE = 3'd4
   } state_e;
endpackage

// File: rtl/spi_byte_mux.sv
// rtl/spi_byte_mux.sv - registered selection of one snapshot byte (MSB byte first), PAD when deselected
module spi_byte_mux #(
   parameter int         NBYTES = 4,
   parameter int         IW     = 3,
   parameter logic [7:0] PAD    = 8'h00
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sel_i,
   input  logic [IW-1:0]     idx_i,
   input  logic [NBYTES*8-1:0] snap_i,
   output logic [7:0]        data_o
);
   logic [7:0] data_d, data_q;

   always_comb begin
      data_d = PAD;
      if (sel_i) begin
         for (int k = 0; k < NBYTES; k++) begin
            if (int'(idx_i) == k) data_d = snap_i[(NBYTES-1-k)*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) data_q <= PAD;
      else     data_q <= data_d;
   end

   assign data_o = data_q;
endmodule

// File: rtl/spi_status_readback.sv
// rtl/spi_status_readback.sv - MISO-side responder returning a status snapshot on a CMD_READ frame
module spi_status_readback #(
   parameter int         NBYTES   = 4,
   parameter logic [7:0] CMD_READ = spi_user_pkg::CMD_READ,
   parameter logic [7:0] PAD      = spi_user_pkg::PAD_BYTE
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [7:0]          usr_mosi_data,
   input  logic                usr_mosi_stb,
   input  logic                usr_miso_ack,
   input  logic                csn_fall,
   input  logic                csn_rise,
   input  logic [NBYTES*8-1:0] status_data,
   output logic [7:0]          usr_miso_data,
   output logic                busy,
   output logic                read_done,
   output logic                overrun,
   output logic [15:0]         read_count
);
   import spi_user_pkg::*;

   localparam int IW = $clog2(NBYTES + 1);

   state_e              state_q, state_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [NBYTES*8-1:0] snap_q, snap_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                overrun_q, overrun_d;
   logic [15:0]         count_q, count_d;

   // Event priority: csn_rise > csn_fall > usr_mosi_stb > usr_miso_ack.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      snap_d    = snap_q;
      overrun_d = overrun_q;
      count_d   = count_q;
      done_d    = 1'b0;
      if (csn_rise) begin
         state_d = ST_IDLE;
         idx_d   = '0;
         if (state_q == ST_DONE) begin
            done_d  = 1'b1;
            count_d = count_q + 16'd1;
         end
      end else if (csn_fall) begin
         state_d = ST_CMD;
         idx_d   = '0;
      end else begin
         case (state_q)
            ST_CMD: begin
               if (usr_mosi_stb) begin
                  if (usr_mosi_data == CMD_READ) begin
                     snap_d  = status_data;
                     idx_d   = '0;
                     state_d = ST_SEND;
                  end else begin
                     state_d = ST_IGNORE;
                  end
               end
            end
            ST_SEND: begin
               if (usr_miso_ack) begin
                  idx_d = idx_q + IW'(1);
                  if (idx_q == IW'(NBYTES - 1)) state_d = ST_DONE;
               end
            end
            ST_DONE: begin
               if (usr_miso_ack) overrun_d = 1'b1;
            end
            default: ;
         endcase
      end
      busy_d = (state_d == ST_SEND) || (state_d == ST_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         snap_q    <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         snap_q    <= snap_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         overrun_q <= overrun_d;
         count_q   <= count_d;
      end
   end

   // The mux registers from next-state values so MISO changes the cycle after the causing strobe.
   spi_byte_mux #(.NBYTES(NBYTES), .IW(IW), .PAD(PAD)) u_mux (
      .clk    (clk),
      .rst    (rst),
      .sel_i  (state_d == ST_SEND),
      .idx_i  (idx_d),
      .snap_i (snap_d),
      .data_o (usr_miso_data)
   );

   assign busy       = busy_q;
   assign read_done  = done_q;
   assign overrun    = overrun_q;
   assign read_count = count_q;
endmodule

// File: tb/tb_spi_status_readback.sv
// tb/tb_spi_status_readback.sv - directed self-checking bench for spi_status_readback
module tb_spi_status_readback;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  usr_mosi_data = 8'h00;
   logic        usr_mosi_stb = 1'b0;
   logic        usr_miso_ack = 1'b0;
   logic        csn_fall = 1'b0;
   logic        csn_rise = 1'b0;
   logic [31:0] status_data = 32'hDEADBEEF;
   logic [7:0]  usr_miso_data;
   logic        busy, read_done, overrun;
   logic [15:0] read_count;

   int checks = 0;
   int errors = 0;

   spi_status_readback dut (
      .clk           (clk),
      .rst           (rst),
      .usr_mosi_data (usr_mosi_data),
      .usr_mosi_stb  (usr_mosi_stb),
      .usr_miso_ack  (usr_miso_ack),
      .csn_fall      (csn_fall),
      .csn_rise      (csn_rise),
      .status_data   (status_data),
      .usr_miso_data (usr_miso_data),
      .busy          (busy),
      .read_done     (read_done),
      .overrun       (overrun),
      .read_count    (read_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Each pulse task drives for one cycle and returns at the next negedge, after the active edge.
   task automatic fall();
      @(negedge clk) csn_fall = 1'b1;
      @(negedge clk) csn_fall = 1'b0;
   endtask

   task automatic rise();
      @(negedge clk) csn_rise = 1'b1;
      @(negedge clk) csn_rise = 1'b0;
   endtask

   task automatic stb(input logic [7:0] b, input logic with_ack);
      @(negedge clk) begin
         usr_mosi_data = b; usr_mosi_stb = 1'b1; usr_miso_ack = with_ack;
      end
      @(negedge clk) begin
         usr_mosi_stb = 1'b0; usr_miso_ack = 1'b0;
      end
   endtask

   task automatic ack();
      @(negedge clk) usr_miso_ack = 1'b1;
      @(negedge clk) usr_miso_ack = 1'b0;
   endtask

   // Issues F5 then four acks, checking the four bytes of word w and the trailing PAD.
   task automatic full_read(input string tag, input logic [31:0] w);
      logic [31:0] v;
      v = w;
      fall();
      stb(8'hF5, 1'b0);
      for (int k = 0; k < 4; k++) begin
         chk({tag, "_byte"}, {24'h0, usr_miso_data}, {24'h0, v[31:24]});
         v = v << 8;
         ack();
      end
      chk({tag, "_pad"}, {24'h0, usr_miso_data}, 32'h00);
      chk({tag, "_busy_done"}, {31'h0, busy}, 32'h1);
   endtask

   initial begin
      #12;
      chk("reset_miso", {24'h0, usr_miso_data}, 32'h00);
      chk("reset_busy", {31'h0, busy}, 32'h0);
      chk("reset_count", {16'h0, read_count}, 32'h0);
      chk("reset_overrun", {31'h0, overrun}, 32'h0);
      @(negedge clk) rst = 1'b0;

      // 1: basic read
      full_read("t1", 32'hDEADBEEF);
      rise();
      chk("t1_read_done", {31'h0, read_done}, 32'h1);
      chk("t1_count", {16'h0, read_count}, 32'd1);
      chk("t1_busy_idle", {31'h0, busy}, 32'h0);
      @(negedge clk);
      chk("t1_done_pulse_1cyc", {31'h0, read_done}, 32'h0);

      // 2: F4 frame is ignored
      fall();
      stb(8'hF4, 1'b0);
      for (int k = 0; k < 4; k++) begin
         stb(8'h11 + 8'(k * 17), 1'b1);
         chk("t2_miso_pad", {24'h0, usr_miso_data}, 32'h00);
         chk("t2_busy", {31'h0, busy}, 32'h0);
      end
      rise();
      chk("t2_no_done", {31'h0, read_done}, 32'h0);
      chk("t2_count", {16'h0, read_count}, 32'd1);

      // 3: short read, then restart at byte 0
      fall();
      stb(8'hF5, 1'b0);
      ack();
      chk("t3_b1", {24'h0, usr_miso_data}, 32'hAD);
      ack();
      rise();
      chk("t3_no_done", {31'h0, read_done}, 32'h0);
      chk("t3_miso_pad", {24'h0, usr_miso_data}, 32'h00);
      full_read("t3r", 32'hDEADBEEF);
      rise();
      chk("t3_count", {16'h0, read_count}, 32'd2);

      // 4: overrun, sticky through the next good read
      full_read("t4", 32'hDEADBEEF);
      chk("t4_no_overrun_yet", {31'h0, overrun}, 32'h0);
      ack();
      chk("t4_overrun", {31'h0, overrun}, 32'h1);
      chk("t4_pad5", {24'h0, usr_miso_data}, 32'h00);
      ack();
      chk("t4_pad6", {24'h0, usr_miso_data}, 32'h00);
      rise();
      chk("t4_done", {31'h0, read_done}, 32'h1);
      full_read("t4g", 32'hDEADBEEF);
      rise();
      chk("t4_overrun_sticky", {31'h0, overrun}, 32'h1);
      chk("t4_count", {16'h0, read_count}, 32'd4);

      // 5: status change mid-frame does not disturb the snapshot
      fall();
      stb(8'hF5, 1'b0);
      status_data = 32'h01020304;
      chk("t5_b0", {24'h0, usr_miso_data}, 32'hDE);
      ack();
      chk("t5_b1", {24'h0, usr_miso_data}, 32'hAD);
      ack();
      chk("t5_b2", {24'h0, usr_miso_data}, 32'hBE);
      ack();
      chk("t5_b3", {24'h0, usr_miso_data}, 32'hEF);
      ack();
      rise();
      full_read("t5n", 32'h01020304);
      rise();
      chk("t5_count", {16'h0, read_count}, 32'd6);

      // ack coincident with the command strobe consumes PAD, byte 0 still follows
      fall();
      stb(8'hF5, 1'b1);
      chk("coinc_b0", {24'h0, usr_miso_data}, 32'h01);
      // csn_fall without a rise abandons the frame
      fall();
      chk("refall_busy", {31'h0, busy}, 32'h0);
      chk("refall_miso", {24'h0, usr_miso_data}, 32'h00);
      rise();
      chk("refall_no_done", {31'h0, read_done}, 32'h0);
      chk("refall_count", {16'h0, read_count}, 32'd6);

      // 6: async reset mid-read
      status_data = 32'hDEADBEEF;
      fall();
      stb(8'hF5, 1'b0);
      ack();
      chk("t6_b1", {24'h0, usr_miso_data}, 32'hAD);
      #2 rst = 1'b1;
      #1;
      chk("t6_async_miso", {24'h0, usr_miso_data}, 32'h00);
      chk("t6_async_busy", {31'h0, busy}, 32'h0);
      chk("t6_async_count", {16'h0, read_count}, 32'h0);
      chk("t6_async_overrun", {31'h0, overrun}, 32'h0);
      @(negedge clk) rst = 1'b0;
      ack();
      chk("t6_after_ack", {24'h0, usr_miso_data}, 32'h00);
      ack();
      rise();
      chk("t6_no_done", {31'h0, read_done}, 32'h0);
      chk("t6_count", {16'h0, read_count}, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
